alu_simd_seq: RTL and testbench

Multi-precision sequencer for the 12-bit `ALU_SIMD` datapath. It accepts one wide command with operands of `12*SLICES` bits and runs it slice by slice through a single ALU instance, least significant slice first. The 2-bit carries returned by the ALU are fed back as the next slice's carry-ins, and the result is assembled into one wide word. It sits between a command producer (valid/ready) and the ALU, and it is the only block that drives the ALU control inputs.

---
 rtl/alu_simd_seq.sv | 156 +++++++++++++++
 tb/tb_alu_simd_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_simd_seq.sv
// Multi-precision sequencer: runs one wide command through a 12-bit ALU,
// one slice per cycle, least significant slice first.
module alu_simd_seq #(
   parameter int SLICES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           cmd,
   input  logic [12*SLICES-1:0] w,
   input  logic [12*SLICES-1:0] x,
   input  logic [12*SLICES-1:0] y,
   input  logic [12*SLICES-1:0] z,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [12*SLICES-1:0] result,
   output logic [1:0]           cout_wxy,
   output logic [1:0]           cout_total,
   output logic [11:0]          alu_w,
   output logic [11:0]          alu_x,
   output logic [11:0]          alu_y,
   output logic [11:0]          alu_z,
   output logic [1:0]           alu_op,
   output logic                 alu_z_ctrl,
   output logic                 alu_s_ctrl,
   output logic                 alu_wxy_ctrl,
   output logic [1:0]           alu_cin_wxy,
   output logic [1:0]           alu_cin_zwxy,
   input  logic [11:0]          alu_s,
   input  logic [1:0]           alu_cout_wxy,
   input  logic [1:0]           alu_cout_zwxy
);

   localparam int N  = 12 * SLICES;
   localparam int IW = (SLICES > 2) ? $clog2(SLICES) : 1;
   localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [2:0] CMD_RSUB = 3'b010;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [2:0]    cmd_q;
   logic [N-1:0]  w_q, x_q, y_q, z_q;
   logic [N-1:0]  res_q;
   logic [1:0]    c_wxy, c_zwxy;

   logic [1:0] dec_op;
   logic       dec_zc, dec_sc, arith;

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign result     = res_q;
   // Logic commands never capture carries, so these stay 0 for them.
   assign cout_wxy   = c_wxy;
   assign cout_total = c_zwxy;

   assign arith = (cmd_q == 3'b000) || (cmd_q == 3'b001) || (cmd_q == 3'b010);

   always_comb begin
      dec_op = 2'b00;
      dec_zc = 1'b0;
      dec_sc = 1'b0;
      unique case (cmd_q)
         3'b000: ;
         3'b001: begin dec_zc = 1'b1; dec_sc = 1'b1; end
         3'b010: dec_zc = 1'b1;
         3'b011: dec_op = 2'b01;
         3'b100: dec_op = 2'b10;
         3'b101: dec_op = 2'b11;
         3'b110: begin dec_op = 2'b10; dec_zc = 1'b1; end
         3'b111: begin dec_op = 2'b11; dec_sc = 1'b1; end
      endcase
   end

   always_comb begin
      alu_w        = '0;
      alu_x        = '0;
      alu_y        = '0;
      alu_z        = '0;
      alu_op       = '0;
      alu_z_ctrl   = 1'b0;
      alu_s_ctrl   = 1'b0;
      alu_wxy_ctrl = 1'b0;
      alu_cin_wxy  = '0;
      alu_cin_zwxy = '0;
      if (state == RUN) begin
         alu_w      = w_q[12*idx +: 12];
         alu_x      = x_q[12*idx +: 12];
         alu_y      = y_q[12*idx +: 12];
         alu_z      = z_q[12*idx +: 12];
         alu_op     = dec_op;
         alu_z_ctrl = dec_zc;
         alu_s_ctrl = dec_sc;
         if (arith) begin
            alu_cin_wxy  = c_wxy;
            alu_cin_zwxy = c_zwxy;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         cmd_q  <= '0;
         w_q    <= '0;
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
         res_q  <= '0;
         c_wxy  <= '0;
         c_zwxy <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cmd_q  <= cmd;
                  w_q    <= w;
                  x_q    <= x;
                  y_q    <= y;
                  z_q    <= z;
                  idx    <= '0;
                  c_wxy  <= '0;
                  // RSUB's +1 of the two's complement enters as carry-in.
                  c_zwxy <= {1'b0, cmd == CMD_RSUB};
                  state  <= RUN;
               end
            end
            RUN: begin
               res_q[12*idx +: 12] <= alu_s;
               if (arith) begin
                  c_wxy  <= alu_cout_wxy;
                  c_zwxy <= alu_cout_zwxy;
               end
               if (idx == LAST) begin
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_simd_seq.sv
// Bench for alu_simd_seq: slice ALU model, wide reference model,
// directed vector table, random commands, backpressure and reset-in-RUN.
module tb_alu_simd_seq;

   localparam int SLICES = 4;
   localparam int N      = 12 * SLICES;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    cmd;
   logic [N-1:0]  w, x, y, z;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  result;
   logic [1:0]    cout_wxy, cout_total;
   logic [11:0]   alu_w, alu_x, alu_y, alu_z;
   logic [1:0]    alu_op;
   logic          alu_z_ctrl, alu_s_ctrl, alu_wxy_ctrl;
   logic [1:0]    alu_cin_wxy, alu_cin_zwxy;
   logic [11:0]   alu_s;
   logic [1:0]    alu_cout_wxy, alu_cout_zwxy;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   alu_simd_seq #(.SLICES(SLICES)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .cmd(cmd),
      .w(w), .x(x), .y(y), .z(z),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout_wxy(cout_wxy), .cout_total(cout_total),
      .alu_w(alu_w), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
      .alu_op(alu_op), .alu_z_ctrl(alu_z_ctrl), .alu_s_ctrl(alu_s_ctrl),
      .alu_wxy_ctrl(alu_wxy_ctrl),
      .alu_cin_wxy(alu_cin_wxy), .alu_cin_zwxy(alu_cin_zwxy),
      .alu_s(alu_s), .alu_cout_wxy(alu_cout_wxy),
      .alu_cout_zwxy(alu_cout_zwxy)
   );

   // 12-bit ALU: adder carries are produced for every op, the sequencer must drop them.
   logic [13:0] a_wxy, a_tot;
   logic [11:0] a_zm, a_pre;
   always_comb begin
      a_zm  = alu_z_ctrl ? ~alu_z : alu_z;
      a_wxy = {2'b0, alu_w} + {2'b0, alu_x} + {2'b0, alu_y} + {12'b0, alu_cin_wxy};
      a_tot = {2'b0, a_zm} + {2'b0, a_wxy[11:0]} + {12'b0, alu_cin_zwxy};
      a_pre = a_tot[11:0];
      case (alu_op)
         2'b01:   a_pre = alu_x ^ alu_y ^ a_zm;
         2'b10:   a_pre = alu_x & a_zm;
         2'b11:   a_pre = alu_x | a_zm;
         default: a_pre = a_tot[11:0];
      endcase
      alu_s         = alu_s_ctrl ? ~a_pre : a_pre;
      alu_cout_wxy  = a_wxy[13:12];
      alu_cout_zwxy = a_tot[13:12];
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   // Wide reference: plain N-bit arithmetic on whole operands.
   task automatic ref_model(input logic [2:0] c, input logic [N-1:0] wi, xi, yi, zi,
                            output logic [N-1:0] r, output logic [1:0] cw, output logic [1:0] ct);
      logic [N+1:0] s3, t;
      s3 = {2'b0, wi} + {2'b0, xi} + {2'b0, yi};
      t  = '0;
      r  = '0;
      cw = 2'd0;
      ct = 2'd0;
      case (c)
         3'd0: t = {2'b0, s3[N-1:0]} + {2'b0, zi};
         3'd1: t = {2'b0, s3[N-1:0]} + {2'b0, ~zi};
         3'd2: t = {2'b0, s3[N-1:0]} + {2'b0, ~zi} + 1;
         3'd3: r = xi ^ yi ^ zi;
         3'd4: r = xi & zi;
         3'd5: r = xi | zi;
         3'd6: r = xi & ~zi;
         default: r = ~(xi | zi);
      endcase
      if (c <= 3'd2) begin
         r  = (c == 3'd1) ? ~t[N-1:0] : t[N-1:0];
         cw = s3[N+1:N];
         ct = t[N+1:N];
      end
   endtask

   function automatic logic [N-1:0] rnd();
      logic [63:0] t;
      case ($urandom_range(0, 3))
         0:       t = '1;
         1:       t = '0;
         default: t = {$urandom(), $urandom()};
      endcase
      return t[N-1:0];
   endfunction

   // Issue one command, scramble inputs during RUN, stall in DONE, handshake.
   task automatic do_cmd(input logic [2:0] c, input logic [N-1:0] wi, xi, yi, zi,
                         input int stall, output logic [N-1:0] r,
                         output logic [1:0] cw, output logic [1:0] ct, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {63'b0, in_ready}, 64'd1);
      cmd = c; w = wi; x = xi; y = yi; z = zi;
      in_valid = 1'b1;
      @(negedge clk);
      lat = 0;
      while (lat < 40) begin
         lat++;
         if (out_valid) break;
         chk("busy_in_ready", {63'b0, in_ready}, 64'd0);
         cmd = 3'($urandom_range(0, 7));
         w = rnd(); x = rnd(); y = rnd(); z = rnd();
         in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      in_valid = 1'b0;
      r  = result;
      cw = cout_wxy;
      ct = cout_total;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         cmd = 3'd0; w = rnd(); x = rnd(); y = rnd(); z = rnd();
         @(negedge clk);
         chk("stall_result", 64'(result), 64'(r));
         chk("stall_valid", {63'b0, out_valid}, 64'd1);
         chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_valid", {63'b0, out_valid}, 64'd0);
      chk("post_in_ready", {63'b0, in_ready}, 64'd1);
   endtask

   // Outside RUN the ALU bus is quiet; logic ops get zero carry-ins.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         chk("wxy_ctrl", {63'b0, alu_wxy_ctrl}, 64'd0);
         if (in_ready || out_valid)
            chk("alu_quiet", {alu_w, alu_x, alu_y, alu_z, alu_op, alu_z_ctrl,
                              alu_s_ctrl, alu_cin_wxy, alu_cin_zwxy}, 64'd0);
         else if (alu_op != 2'b00)
            chk("logic_cin", {60'b0, alu_cin_wxy, alu_cin_zwxy}, 64'd0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [2:0]   c;
      logic [N-1:0] w, x, y, z, r;
      logic [1:0]   cw, ct;
   } vec_t;

   vec_t vt[9];

   initial begin
      logic [N-1:0] r, er;
      logic [1:0]   cw, ct, ecw, ect;
      int           lat;
      logic [2:0]   c;
      logic [N-1:0] a, b, d, e;

      vt[0] = '{c:3'd0, w:48'hFFFFFFFFFFFF, x:48'hFFFFFFFFFFFF, y:48'hFFFFFFFFFFFF,
                z:48'hFFFFFFFFFFFF, r:48'hFFFFFFFFFFFC, cw:2'd2, ct:2'd1};
      vt[1] = '{c:3'd1, w:48'h1, x:48'h0, y:48'h0,
                z:48'h000000001000, r:48'h000000000FFF, cw:2'd0, ct:2'd0};
      vt[2] = '{c:3'd2, w:48'h0, x:48'h0, y:48'h0,
                z:48'h1, r:48'hFFFFFFFFFFFF, cw:2'd0, ct:2'd0};
      vt[3] = '{c:3'd0, w:48'h0, x:48'h0, y:48'h0,
                z:48'h0, r:48'h0, cw:2'd0, ct:2'd0};
      vt[4] = '{c:3'd3, w:48'hFFFFFFFFFFFF, x:48'hAAAAAAAAAAAA, y:48'h555555555555,
                z:48'h0, r:48'hFFFFFFFFFFFF, cw:2'd0, ct:2'd0};
      vt[5] = '{c:3'd7, w:48'hFFFFFFFFFFFF, x:48'h0, y:48'hFFFFFFFFFFFF,
                z:48'h0, r:48'hFFFFFFFFFFFF, cw:2'd0, ct:2'd0};
      vt[6] = '{c:3'd6, w:48'hFFFFFFFFFFFF, x:48'hFFFFFFFFFFFF, y:48'hFFFFFFFFFFFF,
                z:48'h0F0F0F0F0F0F, r:48'hF0F0F0F0F0F0, cw:2'd0, ct:2'd0};
      vt[7] = '{c:3'd4, w:48'h123456789ABC, x:48'hFF00FF00FF00, y:48'h0,
                z:48'h0FF00FF00FF0, r:48'h0F000F000F00, cw:2'd0, ct:2'd0};
      vt[8] = '{c:3'd5, w:48'h0, x:48'hF00000000000, y:48'h0,
                z:48'h000000000001, r:48'hF00000000001, cw:2'd0, ct:2'd0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      cmd = '0; w = '0; x = '0; y = '0; z = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_couts", {60'b0, cout_wxy, cout_total}, 64'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < 9; i++) begin
         do_cmd(vt[i].c, vt[i].w, vt[i].x, vt[i].y, vt[i].z, (i == 0) ? 5 : 0,
                r, cw, ct, lat);
         chk($sformatf("vec%0d_result", i), 64'(r), 64'(vt[i].r));
         chk($sformatf("vec%0d_cout_wxy", i), 64'(cw), 64'(vt[i].cw));
         chk($sformatf("vec%0d_cout_total", i), 64'(ct), 64'(vt[i].ct));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(SLICES + 1));
      end

      for (int i = 0; i < 40; i++) begin
         c = 3'($urandom_range(0, 7));
         a = rnd(); b = rnd(); d = rnd(); e = rnd();
         do_cmd(c, a, b, d, e, $urandom_range(0, 3), r, cw, ct, lat);
         ref_model(c, a, b, d, e, er, ecw, ect);
         chk($sformatf("rnd%0d_cmd%0d_result", i, c), 64'(r), 64'(er));
         chk($sformatf("rnd%0d_cout_wxy", i), 64'(cw), 64'(ecw));
         chk($sformatf("rnd%0d_cout_total", i), 64'(ct), 64'(ect));
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(SLICES + 1));
      end

      // Reset while slice 2 is in the ALU; a concurrent in_valid must be dropped.
      @(negedge clk);
      cmd = 3'd0;
      w = 48'h123456789ABC; x = w; y = w; z = w;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_run_busy", {63'b0, in_ready}, 64'd0);
      rst_n = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      chk("mrst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("mrst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("mrst_result", 64'(result), 64'd0);
      chk("mrst_couts", {60'b0, cout_wxy, cout_total}, 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mrst_no_valid", {63'b0, out_valid}, 64'd0);
      end
      do_cmd(3'd0, 48'd1, 48'd1, 48'd1, 48'd1, 1, r, cw, ct, lat);
      chk("after_rst_sum", 64'(r), 64'd4);
      chk("after_rst_couts", {60'b0, cw, ct}, 64'd0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
